// File: rtl/regfile_mp_pkg.sv
// Shared register-file definitions, also consumed by the decode/hazard unit.
package regfile_mp_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Architectural zero register index.
    localparam int unsigned ZERO_ADDR  = 0;

endpackage : regfile_mp_pkg

// File: rtl/regfile_wr_arb.sv
// Priority resolution of the write ports against one register address.
module regfile_wr_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NWR    = 1
) (
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [NWR-1:0]        i_wr_en,
    input  logic [NWR*ADDR_W-1:0] i_wr_addr,
    input  logic [NWR*DATA_W-1:0] i_wr_data,
    output logic                  o_hit_c,
    output logic [DATA_W-1:0]     o_data_c,
    output logic [NWR-1:0]        o_clr_mask_c
);

    // Ascending scan so the highest-index matching port supplies the data.
    always_comb begin
        o_hit_c      = 1'b0;
        o_data_c     = '0;
        o_clr_mask_c = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_addr)) begin
                o_hit_c         = 1'b1;
                o_data_c        = i_wr_data[j*DATA_W +: DATA_W];
                o_clr_mask_c[j] = 1'b1;
            end
        end
    end

endmodule : regfile_wr_arb

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and pending-write scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [CNT_W-1:0]  r_busy_cnt;

    logic [DEPTH-1:0]  w_st_we;
    logic [DEPTH-1:0]  w_st_clr;
    logic [DATA_W-1:0] w_st_data [DEPTH];
    logic [DEPTH-1:0]  w_busy_nxt;

    function automatic logic [CNT_W-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Per-entry write resolution; the zero register never takes writes or clears.
    for (genvar a = 0; a < DEPTH; a++) begin : g_st
        logic           w_hit;
        logic [NWR-1:0] w_clr_mask;
        logic           w_is_zero;

        assign w_is_zero = (ZERO_REG != 0) && (a == ZERO_ADDR);

        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_arb (
            .i_addr       (ADDR_W'(a)),
            .i_wr_en      (wr_en),
            .i_wr_addr    (wr_addr),
            .i_wr_data    (wr_data),
            .o_hit_c      (w_hit),
            .o_data_c     (w_st_data[a]),
            .o_clr_mask_c (w_clr_mask)
        );

        assign w_st_we[a]  = w_hit && !w_is_zero;
        assign w_st_clr[a] = (|w_clr_mask) && !w_is_zero;
    end

    // Register storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_st_we[i]) begin
                    r_mem[i] <= w_st_data[i];
                end
            end
        end
    end

    // Next busy vector: writeback clears, then a younger issue sets.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_st_clr[i]) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        if (sb_set) begin
            w_busy_nxt[sb_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[ZERO_ADDR] = 1'b0;
        end
    end

    // Scoreboard and its population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= popcnt(w_busy_nxt);
        end
    end

    assign busy_cnt = r_busy_cnt;

    // Read ports with optional same-cycle forwarding.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic [DATA_W-1:0] w_byp_data;
        logic [NWR-1:0]    w_match_mask;
        logic              w_is_zero;
        logic              w_fwd;

        assign w_addr    = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_is_zero = (ZERO_REG != 0) && (w_addr == ADDR_W'(ZERO_ADDR));

        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_arb (
            .i_addr       (w_addr),
            .i_wr_en      (wr_en),
            .i_wr_addr    (wr_addr),
            .i_wr_data    (wr_data),
            .o_hit_c      (w_hit),
            .o_data_c     (w_byp_data),
            .o_clr_mask_c (w_match_mask)
        );

        assign w_fwd = (BYPASS != 0) && w_hit && (|w_match_mask) && !w_is_zero;

        assign rd_data[k*DATA_W +: DATA_W] = w_fwd     ? w_byp_data :
                                             w_is_zero ? '0         : r_mem[w_addr];
        assign rd_busy[k] = !w_fwd && !w_is_zero && r_busy[w_addr];
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench: a forwarding and a non-forwarding instance
// share stimulus and are compared against an architectural register model.
module tb_regfile_mp;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned NR  = 2;
    localparam int unsigned NW  = 2;
    localparam int unsigned DEP = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic [AW:0]      busy_cnt_b, busy_cnt_n;

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] m_mem  [DEP];
    bit            m_busy [DEP];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy_cnt(busy_cnt_b)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(0), .ZERO_REG(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
        .busy_cnt(busy_cnt_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Value a read of addr should see, given the write ports driven right now.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] addr, input bit fwd);
        logic [DW-1:0] v;
        if (addr == 0) return '0;
        v = m_mem[addr];
        if (fwd) begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == addr) v = wr_data[j*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] addr, input bit fwd);
        if (addr == 0) return 1'b0;
        if (fwd) begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == addr) return 1'b0;
            end
        end
        return m_busy[addr];
    endfunction

    task automatic check_all();
        int cnt;
        logic [AW-1:0] a;
        cnt = 0;
        for (int i = 0; i < DEP; i++) cnt += int'(m_busy[i]);
        check_eq("busy_cnt_byp",   64'(busy_cnt_b), 64'(cnt));
        check_eq("busy_cnt_nobyp", 64'(busy_cnt_n), 64'(cnt));
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            check_eq($sformatf("rd%0d_data_byp r%0d", k, a),   64'(rd_data_b[k*DW +: DW]), 64'(exp_rd(a, 1'b1)));
            check_eq($sformatf("rd%0d_data_nobyp r%0d", k, a), 64'(rd_data_n[k*DW +: DW]), 64'(exp_rd(a, 1'b0)));
            check_eq($sformatf("rd%0d_busy_byp r%0d", k, a),   64'(rd_busy_b[k]), 64'(exp_busy(a, 1'b1)));
            check_eq($sformatf("rd%0d_busy_nobyp r%0d", k, a), 64'(rd_busy_n[k]), 64'(exp_busy(a, 1'b0)));
        end
    endtask

    // Architectural effect of one rising edge.
    task automatic model_edge();
        if (!rst_n) return;
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
                m_mem[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
                m_busy[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    endtask

    task automatic cyc(input logic [1:0] en, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        @(negedge clk);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
        sb_set  = s;
        sb_addr = sa;
        rd_addr = {r1, r0};
        #1;
        check_all();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    initial begin
        logic [AW-1:0] ra, rb, wa, wb;
        rst_n = 1'b0;
        idle_inputs();
        rd_addr = {5'd5, 5'd3};
        model_reset();
        #3;
        check_all();
        #20 rst_n = 1'b1;

        // Same-cycle write/read of r3: forwarded on one instance, stale on the other.
        cyc(2'b01, 5'd3, 32'h1234_5678, 5'd0, '0, 1'b0, '0, 5'd3, 5'd3);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd3, 5'd3);

        // Zero register ignores writes and issue marks.
        cyc(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd0, 5'd3);

        // Two ports to r7: port 1 wins in storage and on the bypass path.
        cyc(2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, '0, 5'd7, 5'd7);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd7, 5'd3);

        // Scoreboard on r9: set, writeback+set, writeback alone.
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
        cyc(2'b01, 5'd9, 32'hAA, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd7);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
        cyc(2'b10, 5'd0, '0, 5'd9, 32'hBB, 1'b0, '0, 5'd9, 5'd9);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd9, 5'd9);

        // Fill every nonzero entry, then drain by writebacks two at a time.
        for (int i = 1; i < DEP; i++) cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b1, AW'(i), AW'(i), 5'd1);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd31, 5'd1);
        check_eq("busy_cnt_full", 64'(busy_cnt_b), 64'd31);
        for (int i = 1; i < DEP; i += 2)
            cyc(2'b11, AW'(i), 32'(i * 3), AW'((i + 1) % DEP), 32'(i * 5), 1'b0, '0, AW'(i), 5'd31);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd31, 5'd2);
        check_eq("busy_cnt_drained", 64'(busy_cnt_b), 64'd0);

        // Asynchronous reset mid-cycle after r5 holds a value and r6 is busy.
        cyc(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, '0, 1'b1, 5'd6, 5'd5, 5'd6);
        #2;
        rst_n = 1'b0;
        model_reset();
        idle_inputs();
        rd_addr = {5'd6, 5'd5};
        #1;
        check_all();
        check_eq("reset_r5", 64'(rd_data_n[DW-1:0]), 64'd0);
        cyc(2'b01, 5'd5, 32'h5555, 5'd0, '0, 1'b1, 5'd5, 5'd5, 5'd6);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b01, 5'd5, 32'h6666, 5'd0, '0, 1'b0, '0, 5'd5, 5'd6);
        cyc(2'b00, 5'd0, '0, 5'd0, '0, 1'b0, '0, 5'd5, 5'd6);

        // Random traffic, addresses biased to a small window to provoke conflicts.
        for (int n = 0; n < 600; n++) begin
            wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wb = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            rb = ($urandom_range(0, 2) == 0) ? wb : AW'($urandom);
            cyc(2'($urandom), wa, $urandom, wb, $urandom,
                1'($urandom), ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_regfile_mp
